mrv1_retire_mw: RTL and testbench

//  Multi-threaded, multi-wide retire unit for the mtcore back end. Buffers FU results per thread
//  and per ITAG, and owns each thread's in-order retire head. Each cycle it selects one thread

---
 rtl/mrv1_retire_pkg.sv | 45 ++++
 rtl/mrv1_retire_scan.sv | 102 ++++++++++
 rtl/mrv1_retire_mw.sv | 139 +++++++++++++
 tb/tb_mrv1_retire_mw.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mrv1_retire_pkg.sv
// Shared types and helpers for the mtcore multi-threaded retire unit.
// Used by mrv1_retire_scan and mrv1_retire_mw.
package mrv1_retire_pkg;

    localparam int RET_DATA_W = 32;
    localparam int RET_RFA_W  = 5;

    typedef struct packed {
        logic                 vld;
        logic [RET_RFA_W-1:0] rd_addr;
        logic [RET_DATA_W-1:0] data;
    } retire_wb_s;

    // First requester at or after ptr, rotating over n threads.
    function automatic int unsigned rr_pick(
        input logic [63:0] req,
        input int unsigned ptr,
        input int unsigned n
    );
        int unsigned r;
        int unsigned idx;
        logic        f;
        r = ptr;
        f = 1'b0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < n) begin
                idx = (ptr + i) % n;
                if (!f && req[idx]) begin
                    r = idx;
                    f = 1'b1;
                end
            end
        end
        return r;
    endfunction

    function automatic int unsigned itag_add(
        input int unsigned a,
        input int unsigned b,
        input int unsigned w
    );
        return (a + b) & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/mrv1_retire_scan.sv
// One thread's result buffer plus the in-order candidate scan from its head.
// Set-over-clear on the same edge relies on the protocol keeping ITAGs distinct.
module mrv1_retire_scan
    import mrv1_retire_pkg::*;
#(
    parameter int THREAD_ID_P = 0,
    parameter int TID_W       = 3,
    parameter int ITAG_W      = 3,
    parameter int IQ_SZ       = 8,
    parameter int NUM_FU      = 4,
    parameter int DATA_W      = 32,
    parameter int RFA_W       = 5,
    parameter int RW          = 2,
    parameter int WB          = 2,
    parameter int CNT_W       = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_FU-1:0]                 i_fu_done,
    input  logic [NUM_FU-1:0][TID_W-1:0]      i_fu_tid,
    input  logic [NUM_FU-1:0][ITAG_W-1:0]     i_fu_itag,
    input  logic [NUM_FU-1:0][DATA_W-1:0]     i_fu_data,
    input  logic [IQ_SZ-1:0]                  i_rd_vld,
    input  logic [IQ_SZ-1:0][RFA_W-1:0]       i_rd_addr,
    input  logic [ITAG_W-1:0]                 i_head,
    input  logic                              i_clr,
    input  logic [CNT_W-1:0]                  i_clr_cnt,
    output logic [CNT_W-1:0]                  o_cnt,
    output retire_wb_s [WB-1:0]               o_wb
);

    logic [IQ_SZ-1:0]             r_vld;
    logic [IQ_SZ-1:0][DATA_W-1:0] r_data;
    logic [ITAG_W-1:0]            w_idx;
    logic                         w_stop;
    logic                         w_dup;
    int                           w_port;

    always_comb begin
        o_cnt  = '0;
        o_wb   = '0;
        w_port = 0;
        w_stop = 1'b0;
        w_idx  = '0;
        for (int k = 0; k < RW; k++) begin
            w_idx = ITAG_W'(itag_add(32'(i_head), k, ITAG_W));
            if (!w_stop) begin
                if (!r_vld[w_idx]) begin
                    w_stop = 1'b1;
                end else if (i_rd_vld[w_idx] && w_port == WB) begin
                    w_stop = 1'b1;
                end else begin
                    o_cnt = o_cnt + CNT_W'(1);
                    if (i_rd_vld[w_idx]) begin
                        for (int p = 0; p < WB; p++) begin
                            if (p == w_port) begin
                                o_wb[p].vld     = 1'b1;
                                o_wb[p].rd_addr = i_rd_addr[w_idx];
                                o_wb[p].data    = r_data[w_idx];
                            end
                        end
                        w_port = w_port + 1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_dup = 1'b0;
        for (int j = 0; j < NUM_FU; j++) begin
            if (i_fu_done[j] && i_fu_tid[j] == TID_W'(THREAD_ID_P)
                && r_vld[i_fu_itag[j]])
                w_dup = 1'b1;
        end
    end

    a_no_dup_done: assert property (
        @(posedge clk_i) disable iff (rst_i) !w_dup);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld  <= '0;
            r_data <= '0;
        end else begin
            if (i_clr) begin
                for (int k = 0; k < RW; k++) begin
                    if (k < int'(i_clr_cnt))
                        r_vld[ITAG_W'(itag_add(32'(i_head), k, ITAG_W))] <= 1'b0;
                end
            end
            // Later FUs overwrite earlier ones: highest index wins.
            for (int j = 0; j < NUM_FU; j++) begin
                if (i_fu_done[j] && i_fu_tid[j] == TID_W'(THREAD_ID_P)) begin
                    r_vld[i_fu_itag[j]]  <= 1'b1;
                    r_data[i_fu_itag[j]] <= i_fu_data[j];
                end
            end
        end
    end

endmodule

// File: rtl/mrv1_retire_mw.sv
// Multi-threaded multi-wide retire: round-robin thread pick, heads, registered RF writes.
// Optional MRV1_RETIRE_PERF_EN adds per-thread retired-instruction counters.
module mrv1_retire_mw
    import mrv1_retire_pkg::*;
#(
    parameter int NUM_THREADS_P   = 8,
    parameter int DATA_WIDTH_P    = 32,
    parameter int ITAG_WIDTH_P    = 3,
    parameter int NUM_FU_P        = 4,
    parameter int RETIRE_WIDTH_P  = 2,
    parameter int WB_PORTS_P      = 2,
    parameter int RF_ADDR_WIDTH_P = 5,
    localparam int IQ_SZ_LP       = 2**ITAG_WIDTH_P,
    localparam int TID_WIDTH_LP   = $clog2(NUM_THREADS_P),
    localparam int CNT_WIDTH_LP   = $clog2(RETIRE_WIDTH_P+1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic [NUM_FU_P-1:0]                      fu_done_i,
    input  logic [NUM_FU_P-1:0][DATA_WIDTH_P-1:0]    fu_wb_data_i,
    input  logic [NUM_FU_P-1:0][ITAG_WIDTH_P-1:0]    fu_itag_i,
    input  logic [NUM_FU_P-1:0][TID_WIDTH_LP-1:0]    fu_tid_i,
    input  logic [NUM_THREADS_P-1:0][IQ_SZ_LP-1:0]   iq_rd_vld_i,
    input  logic [NUM_THREADS_P-1:0][IQ_SZ_LP-1:0][RF_ADDR_WIDTH_P-1:0] iq_rd_addr_i,
    input  logic                                     wb_rdy_i,
    output logic                                     retire_vld_o,
    output logic [TID_WIDTH_LP-1:0]                  retire_tid_o,
    output logic [CNT_WIDTH_LP-1:0]                  retire_cnt_o,
    output logic [NUM_THREADS_P-1:0][ITAG_WIDTH_P-1:0] head_itag_o,
`ifdef MRV1_RETIRE_PERF_EN
    output logic [NUM_THREADS_P-1:0][31:0]           perf_ret_cnt_o,
`endif
    output logic [WB_PORTS_P-1:0]                    wb_vld_o,
    output logic [TID_WIDTH_LP-1:0]                  wb_tid_o,
    output logic [WB_PORTS_P-1:0][RF_ADDR_WIDTH_P-1:0] wb_rd_addr_o,
    output logic [WB_PORTS_P-1:0][DATA_WIDTH_P-1:0]  wb_data_o
);

    logic [NUM_THREADS_P-1:0][CNT_WIDTH_LP-1:0]    w_cnt;
    retire_wb_s [NUM_THREADS_P-1:0][WB_PORTS_P-1:0] w_wb;
    logic [NUM_THREADS_P-1:0]                      w_req;
    logic [TID_WIDTH_LP-1:0]                       w_gnt;
    logic [TID_WIDTH_LP-1:0]                       w_ptr_nxt;
    logic                                          w_fire;

    logic [TID_WIDTH_LP-1:0]                       r_ptr;
    logic [NUM_THREADS_P-1:0][ITAG_WIDTH_P-1:0]    r_head;
    logic                                          r_ret_vld;
    logic [TID_WIDTH_LP-1:0]                       r_ret_tid;
    logic [CNT_WIDTH_LP-1:0]                       r_ret_cnt;
    logic [WB_PORTS_P-1:0]                         r_wb_vld;
    logic [WB_PORTS_P-1:0][RF_ADDR_WIDTH_P-1:0]    r_wb_addr;
    logic [WB_PORTS_P-1:0][DATA_WIDTH_P-1:0]       r_wb_data;

    for (genvar t = 0; t < NUM_THREADS_P; t++) begin : g_thr
        mrv1_retire_scan #(
            .THREAD_ID_P (t),
            .TID_W       (TID_WIDTH_LP),
            .ITAG_W      (ITAG_WIDTH_P),
            .IQ_SZ       (IQ_SZ_LP),
            .NUM_FU      (NUM_FU_P),
            .DATA_W      (DATA_WIDTH_P),
            .RFA_W       (RF_ADDR_WIDTH_P),
            .RW          (RETIRE_WIDTH_P),
            .WB          (WB_PORTS_P),
            .CNT_W       (CNT_WIDTH_LP)
        ) u_scan (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .i_fu_done (fu_done_i),
            .i_fu_tid  (fu_tid_i),
            .i_fu_itag (fu_itag_i),
            .i_fu_data (fu_wb_data_i),
            .i_rd_vld  (iq_rd_vld_i[t]),
            .i_rd_addr (iq_rd_addr_i[t]),
            .i_head    (r_head[t]),
            .i_clr     (w_fire && w_gnt == TID_WIDTH_LP'(t)),
            .i_clr_cnt (w_cnt[t]),
            .o_cnt     (w_cnt[t]),
            .o_wb      (w_wb[t])
        );
        assign w_req[t] = |w_cnt[t];
    end

    assign w_gnt  = TID_WIDTH_LP'(rr_pick(64'(w_req), 32'(r_ptr), NUM_THREADS_P));
    assign w_fire = (|w_req) & wb_rdy_i;
    assign w_ptr_nxt = (w_gnt == TID_WIDTH_LP'(NUM_THREADS_P-1)) ? '0
                     : w_gnt + TID_WIDTH_LP'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr     <= '0;
            r_head    <= '0;
            r_ret_vld <= 1'b0;
            r_ret_tid <= '0;
            r_ret_cnt <= '0;
            r_wb_vld  <= '0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_ret_vld <= w_fire;
            r_ret_tid <= w_fire ? w_gnt : '0;
            r_ret_cnt <= w_fire ? w_cnt[w_gnt] : '0;
            for (int p = 0; p < WB_PORTS_P; p++) begin
                r_wb_vld[p]  <= w_fire & w_wb[w_gnt][p].vld;
                r_wb_addr[p] <= w_fire ? w_wb[w_gnt][p].rd_addr : '0;
                r_wb_data[p] <= w_fire ? w_wb[w_gnt][p].data : '0;
            end
            if (w_fire) begin
                r_ptr         <= w_ptr_nxt;
                r_head[w_gnt] <= ITAG_WIDTH_P'(itag_add(32'(r_head[w_gnt]),
                                 32'(w_cnt[w_gnt]), ITAG_WIDTH_P));
            end
        end
    end

`ifdef MRV1_RETIRE_PERF_EN
    logic [NUM_THREADS_P-1:0][31:0] r_perf;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_perf <= '0;
        else if (w_fire)
            r_perf[w_gnt] <= r_perf[w_gnt] + 32'(w_cnt[w_gnt]);
    end

    assign perf_ret_cnt_o = r_perf;
`endif

    assign retire_vld_o = r_ret_vld;
    assign retire_tid_o = r_ret_tid;
    assign retire_cnt_o = r_ret_cnt;
    assign head_itag_o  = r_head;
    assign wb_vld_o     = r_wb_vld;
    assign wb_tid_o     = r_ret_tid;
    assign wb_rd_addr_o = r_wb_addr;
    assign wb_data_o    = r_wb_data;

endmodule

// File: tb/tb_mrv1_retire_mw.sv
// Directed bench for mrv1_retire_mw: default build (2 WB ports) and a 1-port copy.
// Perf counter checks run when MRV1_RETIRE_PERF_EN is defined.
module tb_mrv1_retire_mw;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic [3:0]             fu_done_i;
    logic [3:0][31:0]       fu_wb_data_i;
    logic [3:0][2:0]        fu_itag_i;
    logic [3:0][2:0]        fu_tid_i;
    logic [7:0][7:0]        iq_rd_vld_i;
    logic [7:0][7:0][4:0]   iq_rd_addr_i;
    logic                   wb_rdy_i;

    logic                   m_vld, q_vld;
    logic [2:0]             m_tid, q_tid, m_wtid, q_wtid;
    logic [1:0]             m_cnt, q_cnt;
    logic [7:0][2:0]        m_head, q_head;
    logic [1:0]             m_wvld;
    logic [0:0]             q_wvld;
    logic [1:0][4:0]        m_addr;
    logic [0:0][4:0]        q_addr;
    logic [1:0][31:0]       m_data;
    logic [0:0][31:0]       q_data;
`ifdef MRV1_RETIRE_PERF_EN
    logic [7:0][31:0]       m_perf, q_perf;
`endif

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk_i = ~clk_i;

    mrv1_retire_mw u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .fu_done_i(fu_done_i), .fu_wb_data_i(fu_wb_data_i),
        .fu_itag_i(fu_itag_i), .fu_tid_i(fu_tid_i),
        .iq_rd_vld_i(iq_rd_vld_i), .iq_rd_addr_i(iq_rd_addr_i),
        .wb_rdy_i(wb_rdy_i),
        .retire_vld_o(m_vld), .retire_tid_o(m_tid), .retire_cnt_o(m_cnt),
        .head_itag_o(m_head),
`ifdef MRV1_RETIRE_PERF_EN
        .perf_ret_cnt_o(m_perf),
`endif
        .wb_vld_o(m_wvld), .wb_tid_o(m_wtid),
        .wb_rd_addr_o(m_addr), .wb_data_o(m_data)
    );

    mrv1_retire_mw #(.WB_PORTS_P(1)) u_p1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .fu_done_i(fu_done_i), .fu_wb_data_i(fu_wb_data_i),
        .fu_itag_i(fu_itag_i), .fu_tid_i(fu_tid_i),
        .iq_rd_vld_i(iq_rd_vld_i), .iq_rd_addr_i(iq_rd_addr_i),
        .wb_rdy_i(wb_rdy_i),
        .retire_vld_o(q_vld), .retire_tid_o(q_tid), .retire_cnt_o(q_cnt),
        .head_itag_o(q_head),
`ifdef MRV1_RETIRE_PERF_EN
        .perf_ret_cnt_o(q_perf),
`endif
        .wb_vld_o(q_wvld), .wb_tid_o(q_wtid),
        .wb_rd_addr_o(q_addr), .wb_data_o(q_data)
    );

    function automatic logic [31:0] dval(input int tid, input int itag);
        return 32'hD000_0000 | 32'(tid << 8) | 32'(itag);
    endfunction

    function automatic logic [4:0] aval(input int tid, input int itag);
        return 5'((tid * 8 + itag) % 32);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_fu();
        fu_done_i    = '0;
        fu_wb_data_i = '0;
        fu_itag_i    = '0;
        fu_tid_i     = '0;
    endtask

    task automatic fu(input int j, input int tid, input int itag);
        fu_done_i[j]    = 1'b1;
        fu_tid_i[j]     = 3'(tid);
        fu_itag_i[j]    = 3'(itag);
        fu_wb_data_i[j] = dval(tid, itag);
    endtask

    // Completes itags 0..n-1 of one thread, four per cycle.
    task automatic fill(input int tid, input int n);
        for (int i = 0; i < n; i++) begin
            fu(i % 4, tid, i);
            if (i % 4 == 3 || i == n - 1) begin
                tick();
                clr_fu();
            end
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clr_fu();
        wb_rdy_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        clr_fu();
        wb_rdy_i = 1'b1;
        iq_rd_vld_i = '1;
        for (int t = 0; t < 8; t++)
            for (int i = 0; i < 8; i++)
                iq_rd_addr_i[t][i] = aval(t, i);
        #1;
        chk("rst_vld", 64'(m_vld), 64'd0);
        chk("rst_head", 64'(m_head), 64'd0);
        tick();
        rst_i = 1'b0;

        // Reset mid-traffic
        fu(0, 0, 0); fu(1, 0, 1); fu(2, 0, 2);
        tick(); clr_fu();
        tick();
        chk("pre_rst_vld", 64'(m_vld), 64'd1);
        chk("pre_rst_head", 64'(m_head[0]), 64'd2);
        #2 rst_i = 1'b1;
        #1;
        chk("async_vld", 64'(m_vld), 64'd0);
        chk("async_cnt", 64'(m_cnt), 64'd0);
        chk("async_wvld", 64'(m_wvld), 64'd0);
        chk("async_data", 64'(m_data), 64'd0);
        chk("async_head", 64'(m_head), 64'd0);
        chk("async_p1_head", 64'(q_head), 64'd0);
        @(negedge clk_i) rst_i = 1'b0;
        tick(); tick();
        chk("post_rst_empty", 64'(m_vld), 64'd0);

        // Three completions, two per cycle
        do_reset();
        fu(0, 0, 0); fu(1, 0, 1); fu(2, 0, 2);
        tick(); clr_fu();
        chk("t2_latency", 64'(m_vld), 64'd0);
        tick();
        chk("t2_c1_cnt", 64'(m_cnt), 64'd2);
        chk("t2_c1_tid", 64'(m_tid), 64'd0);
        chk("t2_c1_wvld", 64'(m_wvld), 64'b11);
        chk("t2_c1_a0", 64'(m_addr[0]), 64'(aval(0, 0)));
        chk("t2_c1_d0", 64'(m_data[0]), 64'(dval(0, 0)));
        chk("t2_c1_a1", 64'(m_addr[1]), 64'(aval(0, 1)));
        chk("t2_c1_d1", 64'(m_data[1]), 64'(dval(0, 1)));
        tick();
        chk("t2_c2_cnt", 64'(m_cnt), 64'd1);
        chk("t2_c2_wvld", 64'(m_wvld), 64'b01);
        chk("t2_c2_d0", 64'(m_data[0]), 64'(dval(0, 2)));
        chk("t2_c2_d1", 64'(m_data[1]), 64'd0);
        chk("t2_head", 64'(m_head[0]), 64'd3);
        tick();
        chk("t2_idle", 64'(m_vld), 64'd0);

        // itag1 has no rd; 1-port copy stops before a second write
        do_reset();
        iq_rd_vld_i[0] = 8'b1111_1101;
        fu(0, 0, 0); fu(1, 0, 1); fu(2, 0, 2); fu(3, 0, 3);
        tick(); clr_fu();
        tick();
        chk("t3_p1_c1_cnt", 64'(q_cnt), 64'd2);
        chk("t3_p1_c1_wvld", 64'(q_wvld), 64'd1);
        chk("t3_p1_c1_d0", 64'(q_data[0]), 64'(dval(0, 0)));
        chk("t3_m_c1_wvld", 64'(m_wvld), 64'b01);
        chk("t3_m_c1_cnt", 64'(m_cnt), 64'd2);
        tick();
        chk("t3_p1_c2_cnt", 64'(q_cnt), 64'd1);
        chk("t3_p1_c2_d0", 64'(q_data[0]), 64'(dval(0, 2)));
        chk("t3_m_c2_cnt", 64'(m_cnt), 64'd2);
        chk("t3_m_c2_d1", 64'(m_data[1]), 64'(dval(0, 3)));
        tick();
        chk("t3_p1_c3_cnt", 64'(q_cnt), 64'd1);
        chk("t3_p1_c3_a0", 64'(q_addr[0]), 64'(aval(0, 3)));
        chk("t3_p1_head", 64'(q_head[0]), 64'd4);
        iq_rd_vld_i = '1;

        // Round-robin over T1, T3, T5 with a wb_rdy_i stall
        do_reset();
        wb_rdy_i = 1'b0;
        fill(1, 8); fill(3, 8); fill(5, 8);
        chk("t4_stall_fill", 64'(m_vld), 64'd0);
        wb_rdy_i = 1'b1;
        tick();
        chk("t4_g0", 64'(m_tid), 64'd1);
        chk("t4_g0_cnt", 64'(m_cnt), 64'd2);
        tick();
        chk("t4_g1", 64'(m_tid), 64'd3);
        tick();
        chk("t4_g2", 64'(m_tid), 64'd5);
        chk("t4_g2_wtid", 64'(m_wtid), 64'd5);
        tick();
        chk("t4_g3", 64'(m_tid), 64'd1);
        chk("t4_head1", 64'(m_head[1]), 64'd4);
        wb_rdy_i = 1'b0;
        tick();
        chk("t4_stall_vld", 64'(m_vld), 64'd0);
        chk("t4_stall_wvld", 64'(m_wvld), 64'd0);
        chk("t4_stall_head1", 64'(m_head[1]), 64'd4);
        wb_rdy_i = 1'b1;
        tick();
        chk("t4_g4", 64'(m_tid), 64'd3);
        chk("t4_head3", 64'(m_head[3]), 64'd4);
        chk("t4_head5", 64'(m_head[5]), 64'd2);

        // Head wrap 7 -> 0
        do_reset();
        wb_rdy_i = 1'b0;
        fill(0, 7);
        wb_rdy_i = 1'b1;
        tick(); tick(); tick(); tick();
        chk("t5_last_cnt", 64'(m_cnt), 64'd1);
        chk("t5_head7", 64'(m_head[0]), 64'd7);
        fu(0, 0, 7); fu(1, 0, 0);
        tick(); clr_fu();
        chk("t5_gap", 64'(m_vld), 64'd0);
        tick();
        chk("t5_wrap_cnt", 64'(m_cnt), 64'd2);
        chk("t5_wrap_d0", 64'(m_data[0]), 64'(dval(0, 7)));
        chk("t5_wrap_d1", 64'(m_data[1]), 64'(dval(0, 0)));
        chk("t5_wrap_head", 64'(m_head[0]), 64'd1);

`ifdef MRV1_RETIRE_PERF_EN
        do_reset();
        wb_rdy_i = 1'b0;
        fill(2, 8);
        wb_rdy_i = 1'b1;
        tick(); tick(); tick(); tick();
        chk("t6_perf8", 64'(m_perf[2]), 64'd8);
        fu(0, 2, 0); fu(1, 2, 1);
        tick(); clr_fu();
        tick();
        chk("t6_perf10", 64'(m_perf[2]), 64'd10);
        chk("t6_perf_t0", 64'(m_perf[0]), 64'd0);
        chk("t6_perf_t5", 64'(m_perf[5]), 64'd0);
        chk("t6_p1_perf", 64'(q_perf[2]), 64'd6);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
